regfile_multiport: RTL
======================

REGFILE_MULTIPORT -- requirements
Module: regfile_multiport

Interface
REQ-001 The block SHALL have parameter DATA_W, default 6, meaning register width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 6, meaning address width.
REQ-003 The block SHALL have parameter DEPTH, default 63, meaning number of writable registers, addressed 1..DEPTH, with DEPTH <= 2^ADDR_W-1.
REQ-004 The block SHALL have parameter NUM_RD, default 2, meaning number of read ports, 1..4.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 The block SHALL have port wr_en, input, 1 bit: write request.
REQ-008 The block SHALL have port wr_addr, input, ADDR_W bits: write address.
REQ-009 The block SHALL have port wr_data, input, DATA_W bits: write data.
REQ-010 The block SHALL have port rd_addr, input, NUM_RD*ADDR_W bits: flattened read addresses, with port k at bits [k*ADDR_W +: ADDR_W].
REQ-011 The block SHALL have port rd_data, output, NUM_RD*DATA_W bits: flattened registered read data, with port k at bits [k*DATA_W +: DATA_W].
REQ-012 The block SHALL have port clr_req, input, 1 bit: start a sequential scrub of all registers.
REQ-013 The block SHALL have port clr_busy, output, 1 bit: high while a scrub is in progress.
REQ-014 The block SHALL have port addr_err, output, 1 bit: one-cycle pulse flagging an out-of-range access.

Function
REQ-015 Address 0 SHALL read as all zeros, and writes to address 0 SHALL be discarded without raising addr_err.
REQ-016 A write with wr_en=1 and 1<=wr_addr<=DEPTH SHALL update that register at the rising edge.
REQ-017 Each read port SHALL be sampled at a rising edge, and rd_data for that port SHALL present the result from that edge until the next edge (1-cycle latency).
REQ-018 When a read address equals the accepted write address in the same cycle, rd_data SHALL return the new wr_data (write-first bypass), independently on every port.
REQ-019 Any number of read ports SHALL be allowed to access the same address in the same cycle with identical results.
REQ-020 Addresses greater than DEPTH SHALL be out of range.
REQ-021 An out-of-range write SHALL be ignored.
REQ-022 An out-of-range read SHALL return zero.
REQ-023 Any out-of-range access in a cycle, on the write port (wr_en=1) or on any read port, SHALL drive addr_err=1 in the next cycle.
REQ-024 The scrub controller SHALL have two states: IDLE and CLEAR.
REQ-025 In IDLE with clr_req=1, the controller SHALL move to CLEAR, load scrub pointer=1 and set clr_busy=1 from the next cycle.
REQ-026 In CLEAR, one register (the one at the scrub pointer) SHALL be zeroed per cycle, and the pointer SHALL increment.
REQ-027 The controller SHALL return to IDLE after zeroing register DEPTH, so that clr_busy is high for exactly DEPTH cycles.
REQ-028 During CLEAR, external writes SHALL be dropped, reads SHALL return zero, and no bypass SHALL occur.
REQ-029 clr_req asserted during CLEAR SHALL be ignored and SHALL NOT restart or extend the scrub.
REQ-030 A write accepted in the same cycle as the clr_req that starts a scrub SHALL complete and SHALL then be scrubbed.
REQ-031 The scrub pointer SHALL be ADDR_W bits wide and SHALL NOT wrap past DEPTH.

Reset
REQ-032 When reset=1, the block SHALL immediately, without waiting for clk, set all registers to 0, set rd_data=0, set clr_busy=0, set addr_err=0 and set the controller to IDLE.
REQ-033 Reset asserted during CLEAR SHALL abort the scrub, with the block in IDLE after reset release.
REQ-034 Reset asserted during a write SHALL discard that write.
REQ-035 The first rising edge after reset deasserts SHALL be a normal operating edge.

Structure
REQ-036 Package regfile_pkg SHALL hold the scrub state enum (IDLE, CLEAR) and the default parameter constants.
REQ-037 The scrub FSM and pointer SHALL be a sub-module regfile_clr_seq, with outputs clr_busy, clr_we and clr_addr.
REQ-038 Storage, bypass and per-port read logic SHALL be generated by a loop over NUM_RD inside regfile_multiport.

Verification
REQ-039 Reset scenario: DATA_W=6, NUM_RD=2; after reset, read addresses 1, 63 and 0 -> rd_data=0 on both ports, addr_err=0.
REQ-040 Write/read scenario: write 0x2A to address 5; next cycle read address 5 on port 0 and address 0 on port 1 -> port 0 returns 0x2A, port 1 returns 0.
REQ-041 Bypass scenario: in one cycle write 0x15 to address 7 and read address 7 on both ports -> both return 0x15 at the next edge.
REQ-042 Range scenario: DEPTH=40; write to address 50 and read address 45 -> addr_err pulses for exactly one cycle, rd_data=0, address 50 remains unwritten.
REQ-043 Scrub scenario: fill addresses 1..63 with 0x3F; pulse clr_req -> clr_busy is high for exactly 63 cycles, writes during the scrub are dropped, all reads after the scrub return 0, and a second clr_req during the scrub has no effect.
REQ-044 Reset-abort scenario: assert reset for one cycle at scrub cycle 10 -> clr_busy falls immediately, and a new write/read to address 20 afterwards works normally.

Source files
------------

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults and scrub state encoding for the multiport register file
package regfile_pkg;
  localparam int DATA_W_DEF = 6;
  localparam int ADDR_W_DEF = 6;
  localparam int DEPTH_DEF = 63;
  localparam int NUM_RD_DEF = 2;
  typedef enum logic {IDLE, CLEAR} scrub_state_e;
endpackage

// File: rtl/regfile_clr_seq.sv
// regfile_clr_seq: walks addresses 1..DEPTH zeroing one register per cycle
module regfile_clr_seq import regfile_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH);
  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);
  scrub_state_e state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    if (state_q == IDLE && clr_req) begin
      state_d = CLEAR;
      ptr_d = ONE;
    end else if (state_q == CLEAR) begin
      state_d = (ptr_q == LAST) ? IDLE : CLEAR;
      ptr_d = (ptr_q == LAST) ? ptr_q : ptr_q + ONE;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
    end
  end
  assign clr_busy = state_q == CLEAR;
  assign clr_we = clr_busy;
  assign clr_addr = ptr_q;
endmodule

// File: rtl/regfile_multiport.sv
// regfile_multiport: 1W/NUM_RD-R register file with write-first bypass, range check and scrub
module regfile_multiport import regfile_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int NUM_RD = NUM_RD_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic                     clr_req,
  output logic                     clr_busy,
  output logic                     addr_err
);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH);
  logic [DATA_W-1:0] mem_q [1:DEPTH];
  logic [DATA_W-1:0] mem_d [1:DEPTH];
  logic clr_we, wr_oob, wr_ok, addr_err_q, addr_err_d;
  logic [ADDR_W-1:0] clr_addr;
  logic [NUM_RD-1:0] rd_oob;
  regfile_clr_seq #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_clr (
    .clk(clk), .reset(reset), .clr_req(clr_req),
    .clr_busy(clr_busy), .clr_we(clr_we), .clr_addr(clr_addr)
  );
  assign wr_oob = wr_en && wr_addr > LAST;
  // address 0 is a hardwired zero, so writes to it vanish silently
  assign wr_ok = wr_en && wr_addr != '0 && !wr_oob && !clr_busy;
  always_comb begin
    mem_d = mem_q;
    if (clr_we) mem_d[clr_addr] = '0;
    else if (wr_ok) mem_d[wr_addr] = wr_data;
  end
  assign addr_err_d = wr_oob | (|rd_oob);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q <= '{default: '0};
      addr_err_q <= 1'b0;
    end else begin
      mem_q <= mem_d;
      addr_err_q <= addr_err_d;
    end
  end
  assign addr_err = addr_err_q;
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] rd_q, rd_d;
    assign a = rd_addr[k*ADDR_W +: ADDR_W];
    assign rd_oob[k] = a > LAST;
    always_comb rd_d = (clr_busy || rd_oob[k] || a == '0) ? '0 :
                       (wr_ok && a == wr_addr) ? wr_data : mem_q[a];
    always_ff @(posedge clk or posedge reset) begin
      if (reset) rd_q <= '0;
      else rd_q <= rd_d;
    end
    assign rd_data[k*DATA_W +: DATA_W] = rd_q;
  end
endmodule
